// File: rtl/adc_sched_pkg.sv
// -----------------------------------------------------------------------------
// Package: adc_sched_pkg
// Shared types and constants for the ADC scan scheduler.
//   NUM_CHAN / CHAN_W : ADC channel count and channel index width
//   AVG_N             : conversions per target when averaging is built in
//   state_t           : scheduler FSM state encoding
//   lowest_set()      : index of the lowest set bit of a channel mask
// -----------------------------------------------------------------------------
package adc_sched_pkg;

  localparam int NUM_CHAN = 8;
  localparam int CHAN_W   = 3;
  localparam int AVG_N    = 4;

  // Fixed encodings so the state value matches older debug tooling.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_START   = 2'd1,
    ST_CONV    = 2'd2,
    ST_PUBLISH = 2'd3
  } state_t;

  // Priority encoder. Walking from the top down leaves the lowest set bit
  // as the final assignment. Returns 0 for an empty mask, so callers must
  // check for an empty mask themselves.
  function automatic logic [CHAN_W-1:0] lowest_set(input logic [NUM_CHAN-1:0] mask);
    lowest_set = '0;
    for (int i = NUM_CHAN - 1; i >= 0; i--) begin
      if (mask[i]) lowest_set = CHAN_W'(i);
    end
  endfunction

endpackage

// File: rtl/adc_period_timer.sv
// -----------------------------------------------------------------------------
// Module: adc_period_timer
// Free-running down-counter that marks the start of each sample period.
//   clk    in  system clock
//   reset  in  asynchronous active-high reset (counter loads PERIOD-1)
//   enable in  1 = count, 0 = hold current value
//   tick   out one-cycle pulse while enabled and the counter is at 0
// Parameter PERIOD (>=2): clocks between ticks.
// -----------------------------------------------------------------------------
module adc_period_timer #(
  parameter int PERIOD = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int              CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(PERIOD - 1);

  logic [CNT_W-1:0] count;

  // NOTE: sequential state is assigned with <= so that every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= RELOAD;
    end else if (enable) begin
      count <= (count == '0) ? RELOAD : count - 1'b1;
    end
  end

  // The tick is decoded combinationally so the scheduler sees it in the
  // same cycle the counter reaches zero.
  assign tick = enable && (count == '0);

endmodule

// File: rtl/adc_scan_sched.sv
// -----------------------------------------------------------------------------
// Module: adc_scan_sched
// Sequences the shared ADC once per sample period: one manually selected
// channel, or every channel enabled in a scan mask. Each result is published
// as a one-cycle tagged pulse.
//   clk, reset            clock; asynchronous active-high reset
//   enable                1 = periodic rounds run
//   scan_mode             0 = manual (chan_sel), 1 = scan (scan_mask)
//   chan_sel, scan_mask   channel selection, snapshotted at round start
//   adc_start, adc_chan   conversion request to the ADC
//   adc_done, adc_data    conversion completion from the ADC
//   res_valid             one-cycle result pulse
//   res_chan, res_data    published channel/result, held until next publish
//   busy                  1 while a round is in progress
//   timeout_err           sticky, set when the ADC fails to answer in time
// Build option: define ADC_SCHED_AVG_EN to convert each target AVG_N times
// back-to-back and publish the truncated mean.
// -----------------------------------------------------------------------------
module adc_scan_sched
  import adc_sched_pkg::*;
#(
  parameter int DATA_W  = 12,
  parameter int PERIOD  = 50000,
  parameter int TIMEOUT = 1023
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                scan_mode,
  input  logic [CHAN_W-1:0]   chan_sel,
  input  logic [NUM_CHAN-1:0] scan_mask,
  output logic                adc_start,
  output logic [CHAN_W-1:0]   adc_chan,
  input  logic                adc_done,
  input  logic [DATA_W-1:0]   adc_data,
  output logic                res_valid,
  output logic [CHAN_W-1:0]   res_chan,
  output logic [DATA_W-1:0]   res_data,
  output logic                busy,
  output logic                timeout_err
);

  localparam int              TO_W    = $clog2(TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  state_t              state;
  logic                tick;
  logic                scan_r;     // mode snapshot for the current round
  logic [NUM_CHAN-1:0] pending;    // scan channels not yet published
  logic [NUM_CHAN-1:0] pend_rest;  // pending without the current target
  logic [CHAN_W-1:0]   target;
  logic [TO_W-1:0]     to_cnt;

  adc_period_timer #(.PERIOD(PERIOD)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .tick   (tick)
  );

  assign pend_rest = pending & ~(NUM_CHAN'(1) << target);

`ifdef ADC_SCHED_AVG_EN
  localparam int REP_W = $clog2(AVG_N);

  logic [REP_W-1:0]  rep;
  logic [DATA_W+1:0] acc;
  logic [DATA_W+1:0] acc_sum;

  assign acc_sum = acc + (DATA_W+2)'(adc_data);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      scan_r      <= 1'b0;
      pending     <= '0;
      target      <= '0;
      to_cnt      <= '0;
      res_chan    <= '0;
      res_data    <= '0;
      timeout_err <= 1'b0;
`ifdef ADC_SCHED_AVG_EN
      rep         <= '0;
      acc         <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          // tick already implies enable; ticks while busy are simply lost.
          if (tick) begin
`ifdef ADC_SCHED_AVG_EN
            rep <= '0;
            acc <= '0;
`endif
            if (!scan_mode) begin
              scan_r  <= 1'b0;
              pending <= '0;
              target  <= chan_sel;
              state   <= ST_START;
            end else if (scan_mask != '0) begin
              scan_r  <= 1'b1;
              pending <= scan_mask;
              target  <= lowest_set(scan_mask);
              state   <= ST_START;
            end
          end
        end

        ST_START: begin
          to_cnt <= '0;
          state  <= ST_CONV;
        end

        ST_CONV: begin
          if (adc_done) begin
`ifdef ADC_SCHED_AVG_EN
            if (rep == REP_W'(AVG_N - 1)) begin
              res_data <= acc_sum[DATA_W+1:2];
              res_chan <= target;
              state    <= ST_PUBLISH;
            end else begin
              acc   <= acc_sum;
              rep   <= rep + 1'b1;
              state <= ST_START;
            end
`else
            res_data <= adc_data;
            res_chan <= target;
            state    <= ST_PUBLISH;
`endif
          end else if (to_cnt == TO_LAST) begin
            // The ADC never answered: drop the whole round.
            timeout_err <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        ST_PUBLISH: begin
`ifdef ADC_SCHED_AVG_EN
          rep <= '0;
          acc <= '0;
`endif
          if (scan_r && (pend_rest != '0)) begin
            pending <= pend_rest;
            target  <= lowest_set(pend_rest);
            state   <= ST_START;
          end else begin
            state <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign adc_start = (state == ST_START);
  assign adc_chan  = target;
  assign res_valid = (state == ST_PUBLISH);
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_adc_scan_sched.sv
// -----------------------------------------------------------------------------
// Testbench: tb_adc_scan_sched
// Drives adc_scan_sched (PERIOD=16, TIMEOUT=8) with a behavioural ADC that
// answers a fixed number of cycles after each start. Expected start channels
// and published results are queued when a round is set up and compared as
// the DUT produces them.
// -----------------------------------------------------------------------------
module tb_adc_scan_sched;
  import adc_sched_pkg::*;

  localparam int DATA_W  = 12;
  localparam int PERIOD  = 16;
  localparam int TIMEOUT = 8;
`ifdef ADC_SCHED_AVG_EN
  localparam int AVG = AVG_N;
`else
  localparam int AVG = 1;
`endif

  logic                clk;
  logic                reset;
  logic                enable;
  logic                scan_mode;
  logic [CHAN_W-1:0]   chan_sel;
  logic [NUM_CHAN-1:0] scan_mask;
  logic                adc_start;
  logic [CHAN_W-1:0]   adc_chan;
  logic                adc_done;
  logic [DATA_W-1:0]   adc_data;
  logic                res_valid;
  logic [CHAN_W-1:0]   res_chan;
  logic [DATA_W-1:0]   res_data;
  logic                busy;
  logic                timeout_err;

  adc_scan_sched #(
    .DATA_W  (DATA_W),
    .PERIOD  (PERIOD),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .scan_mode   (scan_mode),
    .chan_sel    (chan_sel),
    .scan_mask   (scan_mask),
    .adc_start   (adc_start),
    .adc_chan    (adc_chan),
    .adc_done    (adc_done),
    .adc_data    (adc_data),
    .res_valid   (res_valid),
    .res_chan    (res_chan),
    .res_data    (res_data),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [CHAN_W-1:0] chan;
    logic [DATA_W-1:0] data;
  } res_t;

  logic [CHAN_W-1:0] exp_start[$];
  res_t              exp_res[$];
  logic [DATA_W-1:0] chan_data[NUM_CHAN];

  int n_tests = 0;
  int n_fail  = 0;
  bit resp_en;     // behavioural ADC answers starts
  int adc_lat;     // cycles from adc_start to adc_done
  bit busy_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference result: the ADC returns chan_data[ch] + k for the k-th
  // conversion of a target; averaging publishes the truncated mean.
  function automatic res_t model_result(input logic [CHAN_W-1:0] ch);
    logic [13:0] sum;
    res_t        r;
    sum = '0;
    for (int k = 0; k < AVG; k++) sum += 14'(chan_data[ch]) + 14'(k);
    r.chan = ch;
    r.data = (AVG == 1) ? sum[11:0] : sum[13:2];
    return r;
  endfunction

  task automatic push_round(input bit scan, input logic [CHAN_W-1:0] ch,
                            input logic [NUM_CHAN-1:0] mask);
    if (!scan) begin
      repeat (AVG) exp_start.push_back(ch);
      exp_res.push_back(model_result(ch));
    end else begin
      for (int i = 0; i < NUM_CHAN; i++) begin
        if (mask[i]) begin
          repeat (AVG) exp_start.push_back(CHAN_W'(i));
          exp_res.push_back(model_result(CHAN_W'(i)));
        end
      end
    end
  endtask

  // Monitor + behavioural ADC, both evaluated on the falling edge.
  initial begin
    int                cd;
    int                k;
    logic [CHAN_W-1:0] cur;
    res_t              e;
    cd = 0; k = 0; cur = '0;
    adc_done = 1'b0;
    adc_data = '0;
    forever begin
      @(negedge clk);
      busy_seen = busy_seen | busy;
      adc_done  = 1'b0;
      if (!busy) k = 0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          adc_done = 1'b1;
          adc_data = chan_data[cur] + DATA_W'(k);
          k        = (k + 1) % AVG;
        end
      end
      if (adc_start) begin
        if (exp_start.size() == 0) check("unexpected_start", 1, 0);
        else                       check("start_chan", 32'(adc_chan), 32'(exp_start.pop_front()));
        cur = adc_chan;
        if (resp_en) cd = adc_lat;
      end
      if (res_valid) begin
        if (exp_res.size() == 0) begin
          check("unexpected_res", 1, 0);
        end else begin
          e = exp_res.pop_front();
          check("res_chan", 32'(res_chan), 32'(e.chan));
          check("res_data", 32'(res_data), 32'(e.data));
        end
      end
    end
  end

  task automatic do_reset();
    enable = 1'b0;
    reset  = 1'b1;
    repeat (2) @(negedge clk);
    reset  = 1'b0;
  endtask

  task automatic wait_start(input int budget, output int cycles);
    bit seen;
    seen   = 1'b0;
    cycles = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      cycles++;
      if (adc_start) begin
        seen = 1'b1;
        break;
      end
    end
    check("start_wait", 32'(seen), 1);
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy) begin
        ok = 1'b1;
        break;
      end
    end
    check("idle_wait", 32'(ok), 1);
  endtask

  task automatic quiet(input int n);
    busy_seen = 1'b0;
    repeat (n) @(negedge clk);
    check("quiet_busy", 32'(busy_seen), 0);
  endtask

  task automatic drain_check();
    check("start_q_empty", 32'(exp_start.size()), 0);
    check("res_q_empty",   32'(exp_res.size()),   0);
  endtask

  initial begin
    int cyc;
    int n;
    reset     = 1'b1;
    enable    = 1'b0;
    scan_mode = 1'b0;
    chan_sel  = '0;
    scan_mask = '0;
    resp_en   = 1'b1;
    adc_lat   = 3;
    busy_seen = 1'b0;
    for (int i = 0; i < NUM_CHAN; i++) chan_data[i] = DATA_W'(16'h111 * i + 16'h20);

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst_adc_start",   32'(adc_start),   0);
    check("rst_adc_chan",    32'(adc_chan),    0);
    check("rst_res_valid",   32'(res_valid),   0);
    check("rst_res_chan",    32'(res_chan),    0);
    check("rst_res_data",    32'(res_data),    0);
    check("rst_busy",        32'(busy),        0);
    check("rst_timeout_err", 32'(timeout_err), 0);
    reset = 1'b0;

    // 1. Manual channel 5; enable dropped mid-round, round still completes.
    chan_sel     = 3'd5;
    chan_data[5] = 12'hABC;
    push_round(1'b0, 3'd5, '0);
    enable = 1'b1;
    wait_start(40, cyc);
    check("tick_latency", 32'(cyc), PERIOD);
    enable = 1'b0;
    wait_idle(100);
    drain_check();
    quiet(2 * PERIOD);

    // 2. Scan 1010_0101; mid-round input changes must be ignored.
    do_reset();
    scan_mode = 1'b1;
    scan_mask = 8'b1010_0101;
    push_round(1'b1, '0, 8'b1010_0101);
    enable = 1'b1;
    wait_start(40, cyc);
    scan_mask = 8'hFF;
    scan_mode = 1'b0;
    chan_sel  = 3'd1;
    wait_idle(200);
    quiet(4);
    enable = 1'b0;
    drain_check();

    // 3. Scan with empty mask over three periods: nothing happens.
    do_reset();
    scan_mode = 1'b1;
    scan_mask = '0;
    enable    = 1'b1;
    quiet(3 * PERIOD + 4);
    enable = 1'b0;
    drain_check();

    // 4. ADC never answers: abort after TIMEOUT CONV cycles, then recover.
    do_reset();
    resp_en   = 1'b0;
    scan_mode = 1'b0;
    chan_sel  = 3'd2;
    exp_start.push_back(3'd2);
    enable = 1'b1;
    wait_start(40, cyc);
    check("err_before_timeout", 32'(timeout_err), 0);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      n++;
      if (!busy) break;
    end
    check("timeout_len", 32'(n), TIMEOUT + 1);
    check("timeout_err", 32'(timeout_err), 1);
    resp_en  = 1'b1;
    chan_sel = 3'd4;
    push_round(1'b0, 3'd4, '0);
    wait_start(40, cyc);
    wait_idle(100);
    check("timeout_err_sticky", 32'(timeout_err), 1);
    enable = 1'b0;
    drain_check();

    // 5. Reset during CONV; the late adc_done must be ignored.
    adc_lat  = 5;
    chan_sel = 3'd6;
    exp_start.push_back(3'd6);
    enable = 1'b1;
    wait_start(40, cyc);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_busy",        32'(busy),        0);
    check("midrst_adc_start",   32'(adc_start),   0);
    check("midrst_adc_chan",    32'(adc_chan),    0);
    check("midrst_res_chan",    32'(res_chan),    0);
    check("midrst_res_data",    32'(res_data),    0);
    check("midrst_timeout_err", 32'(timeout_err), 0);
    @(negedge clk);
    reset = 1'b0;
    quiet(8);
    enable  = 1'b0;
    adc_lat = 3;
    drain_check();

    // 6. Manual channel 3 with ramping data (averaged when built in).
    do_reset();
    scan_mode    = 1'b0;
    chan_sel     = 3'd3;
    chan_data[3] = 12'd100;
    push_round(1'b0, 3'd3, '0);
    enable = 1'b1;
    wait_start(40, cyc);
    wait_idle(100);
    enable = 1'b0;
    drain_check();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog");
  end

endmodule
